sum_stream_capture: RTL and testbench
=====================================

Name: sum_stream_capture

Overview:
Downstream stage of the past-sequence adder. It takes the adder's free-running DW-bit sum output on `clk`. It discards the pipeline warm-up cycles, then decimates the stream and buffers accepted samples in a small FIFO. The FIFO is drained by a valid/ready consumer, and overflow is flagged so lost sums are visible to software and the test bench.

Parameters:
- DW, 8: data width; matches the adder output width.
- WARMUP, 16: number of enabled cycles discarded before the first sample is taken; legal range ≥0.
- DECIM, 1: take one sample every DECIM cycles after warm-up; legal range ≥1.
- DEPTH, 4: FIFO entries; must be a power of 2 and ≥2.
- AW, log2(DEPTH): pointer width; derived, not overridden.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: capture enable; low means the upstream adder is restarting.
- in_sum, input, DW: sum from the upstream adder, sampled every cycle.
- out_data, output, DW: FIFO head data (first-word-fall-through).
- out_valid, output, 1: FIFO not empty.
- out_ready, input, 1: consumer accepts the head entry this cycle.
- count, output, AW+1: current FIFO occupancy, 0..DEPTH.
- overflow, output, 1: sticky flag; set when a sample was dropped.
- clr_ovf, input, 1: synchronous clear of overflow.

Behaviour:
- **Reset (async, rst=1):**
  - Warm-up counter = 0 and decimation counter = 0.
  - Read and write pointers = 0, count = 0.
  - Storage = 0, so out_data = 0.
  - out_valid = 0, overflow = 0.
  - Reset asserted mid-operation clears everything immediately and discards buffered data. Release is synchronous to clk.
- **Warm-up:**
  - While en=1 and the warm-up counter is below WARMUP, the counter increments each cycle and no sample is taken.
  - Once the counter equals WARMUP it saturates.
  - en=0 synchronously zeroes the warm-up and decimation counters. FIFO contents, count and overflow are preserved.
- **Sample strobe:**
  - Asserted only when en=1 and warm-up is complete and the decimation counter = 0.
  - The decimation counter counts 0..DECIM-1 and wraps, advancing only while en=1 and warm-up is complete.
  - The first strobe fires on the first cycle with warm-up complete. Later strobes fire every DECIM cycles.
  - For WARMUP=0, the strobe fires on the first enabled cycle.
- **Push:** on a strobe, in_sum is written at the write pointer, provided the FIFO is not full or a pop happens in the same cycle.
- **Full FIFO:** if a strobe arrives while full with no pop, the sample is dropped, overflow is set, and pointers are unchanged.
- **Pop:** occurs when out_valid & out_ready. The read pointer advances. out_ready while empty is ignored.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **Pointer wrap:** pointers are AW bits wide and wrap naturally modulo DEPTH. Full/empty status is taken from count, not from pointer comparison.
- **Latency:** a sample strobed in cycle t is visible on out_data/out_valid in cycle t+1 when the FIFO was empty. There is no combinational bypass from in_sum to out_data.
- **Head data:** out_data = storage[read pointer]. The value is don't-care when out_valid=0, except after reset, when it is 0.
- **out_valid and count:** both are registered and update one cycle after the push or pop.
- **Overflow flag:** clr_ovf clears it next cycle. If a clear and a new drop happen in the same cycle, set wins.
- **Arithmetic:** no arithmetic on the data; in_sum is stored unmodified. Counters use unsigned compare only.

Decomposition:
- Shared include `seq_adder_defs.vh` holds:
  - default DW;
  - a `clog2` function, used for AW and the count width;
  - FIFO depth constants shared with the adder bench.
- One sub-module is natural: `sum_fifo`, containing storage, pointers, count, push/pop and full/empty logic.
- The top level holds the warm-up counter, decimation counter, strobe generation and overflow flag.

Test Plan:
1. **Warm-up discard:** WARMUP=3, DECIM=1, en held 1, in_sum=10,11,12,13,14 on cycles 0–4, out_ready=0 → out_valid stays 0 through cycle 3. Cycle 4: out_data=13, out_valid=1, count=1.
2. **Decimation:** WARMUP=0, DECIM=2, in_sum=cycle index 0..7, out_ready=1 → accepted sums are 0, 2, 4, 6, each appearing on out_data one cycle after its strobe.
3. **Overflow:** DEPTH=4, DECIM=1, out_ready=0, in_sum=1..6 → FIFO holds 1, 2, 3, 4 and count=4. overflow=1 after sum 5 is dropped. clr_ovf pulse → overflow=0 next cycle.
4. **Full with simultaneous push and pop:** FIFO full [1,2,3,4], out_ready=1 and strobe with in_sum=5 in the same cycle → count stays 4, overflow stays 0, head becomes 2, order is 2, 3, 4, 5.
5. **Enable drop:** en=0 for one cycle mid-stream with WARMUP=2 → FIFO contents kept. The next 2 enabled cycles are discarded, and sampling then resumes.
6. **Async reset mid-operation:** rst=1 asserted between clock edges with count=3 and overflow=1 → outputs go immediately to count=0, out_valid=0, overflow=0, out_data=0. After release, warm-up restarts from 0.

Source files
------------

// File: rtl/sum_stream_capture_pkg.sv
// rtl/sum_stream_capture_pkg.sv - shared defaults and width helper for the sum capture stage
package sum_stream_capture_pkg;

  localparam int DEF_DW     = 8;
  localparam int DEF_WARMUP = 16;
  localparam int DEF_DECIM  = 1;
  localparam int DEF_DEPTH  = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sum_stream_capture_if.sv
// rtl/sum_stream_capture_if.sv - valid/ready output stream carrying captured sums
interface sum_stream_capture_if #(
  parameter int DW = 8
);
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sum_stream_capture_sum_fifo.sv
// rtl/sum_stream_capture_sum_fifo.sv - first-word-fall-through FIFO with count-based full/empty
module sum_fifo
  import sum_stream_capture_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          rdy,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic [AW:0]   count,
  output logic          dropped
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, pop, wr;

  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = valid && rdy;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr      = push && (!full || pop);
  assign dropped = push && full && !pop;
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      if (wr) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      unique case ({wr, pop})
        2'b10: begin
          count <= count + 1'b1;
          valid <= 1'b1;
        end
        2'b01: begin
          count <= count - 1'b1;
          valid <= (count != (AW+1)'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sum_stream_capture.sv
// rtl/sum_stream_capture.sv - warm-up discard, decimation and buffered capture of adder sums
module sum_stream_capture
  import sum_stream_capture_pkg::*;
#(
  parameter  int DW     = DEF_DW,
  parameter  int WARMUP = DEF_WARMUP,
  parameter  int DECIM  = DEF_DECIM,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AW     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DW-1:0]         in_sum,
  sum_stream_capture_if.master  m,
  output logic [AW:0]           count,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int WW = (clog2(WARMUP + 1) > 0) ? clog2(WARMUP + 1) : 1;
  localparam int CW = (clog2(DECIM) > 0) ? clog2(DECIM) : 1;

  logic [WW-1:0] wcnt;
  logic [CW-1:0] dcnt;
  logic          wdone, strobe, dropped;

  assign wdone  = (wcnt == WW'(WARMUP));
  assign strobe = en && wdone && (dcnt == '0);

  // en low means the adder is restarting: its next outputs are warm-up garbage again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      dcnt <= '0;
    end else if (!en) begin
      wcnt <= '0;
      dcnt <= '0;
    end else if (!wdone) begin
      wcnt <= wcnt + 1'b1;
    end else begin
      dcnt <= (dcnt == CW'(DECIM - 1)) ? '0 : dcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (dropped) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  sum_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (strobe),
    .din     (in_sum),
    .rdy     (m.out_ready),
    .head    (m.out_data),
    .valid   (m.out_valid),
    .count   (count),
    .dropped (dropped)
  );

endmodule

// File: tb/tb_sum_stream_capture.sv
// tb/tb_sum_stream_capture.sv - directed vector bench for sum_stream_capture
module tb_sum_stream_capture;

  typedef struct {
    logic       en;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic       chk_d;
    logic [7:0] ed;
    logic [2:0] ec;
    logic       eo;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_en = 1'b0, a_clr = 1'b0, b_en = 1'b0, b_clr = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic [2:0] a_count, b_count;
  logic       a_ovf, b_ovf;
  int         total = 0;
  int         passed = 0;
  vec_t       tv [22];

  always #5 clk = ~clk;

  sum_stream_capture_if #(.DW(8)) a_if ();
  sum_stream_capture_if #(.DW(8)) b_if ();

  sum_stream_capture #(.DW(8), .WARMUP(3), .DECIM(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .in_sum(a_in), .m(a_if),
    .count(a_count), .overflow(a_ovf), .clr_ovf(a_clr)
  );

  sum_stream_capture #(.DW(8), .WARMUP(0), .DECIM(2), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .in_sum(b_in), .m(b_if),
    .count(b_count), .overflow(b_ovf), .clr_ovf(b_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    a_if.out_ready = 1'b0;
    b_if.out_ready = 1'b0;

    //        en din rdy clr  ev chk ed  ec eo
    tv[0]  = '{1, 10, 0, 0,   0, 1,  0, 0, 0};
    tv[1]  = '{1, 11, 0, 0,   0, 1,  0, 0, 0};
    tv[2]  = '{1, 12, 0, 0,   0, 1,  0, 0, 0};
    tv[3]  = '{1, 13, 0, 0,   0, 1,  0, 0, 0};
    tv[4]  = '{1, 14, 0, 0,   1, 1, 13, 1, 0};
    tv[5]  = '{1, 15, 0, 0,   1, 1, 13, 2, 0};
    tv[6]  = '{1, 16, 0, 0,   1, 1, 13, 3, 0};
    tv[7]  = '{1, 17, 0, 0,   1, 1, 13, 4, 0};
    tv[8]  = '{0,  0, 0, 1,   1, 1, 13, 4, 1};
    tv[9]  = '{0,  0, 0, 0,   1, 1, 13, 4, 0};
    tv[10] = '{1, 20, 0, 0,   1, 1, 13, 4, 0};
    tv[11] = '{1, 21, 0, 0,   1, 1, 13, 4, 0};
    tv[12] = '{1, 22, 0, 0,   1, 1, 13, 4, 0};
    tv[13] = '{1, 23, 1, 0,   1, 1, 13, 4, 0};
    tv[14] = '{1, 24, 0, 1,   1, 1, 14, 4, 0};
    tv[15] = '{0,  0, 1, 0,   1, 1, 14, 4, 1};
    tv[16] = '{0,  0, 1, 0,   1, 1, 15, 3, 1};
    tv[17] = '{0,  0, 1, 0,   1, 1, 16, 2, 1};
    tv[18] = '{0,  0, 1, 0,   1, 1, 23, 1, 1};
    tv[19] = '{0,  0, 1, 0,   0, 0,  0, 0, 1};
    tv[20] = '{0,  0, 0, 1,   0, 0,  0, 0, 1};
    tv[21] = '{0,  0, 0, 0,   0, 0,  0, 0, 0};

    @(negedge clk);
    chk("reset_valid", a_if.out_valid, 0);
    chk("reset_data", a_if.out_data, 0);
    chk("reset_count", a_count, 0);
    chk("reset_ovf", a_ovf, 0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      chk($sformatf("a%0d_valid", i), a_if.out_valid, tv[i].ev);
      if (tv[i].chk_d) chk($sformatf("a%0d_data", i), a_if.out_data, tv[i].ed);
      chk($sformatf("a%0d_count", i), a_count, tv[i].ec);
      chk($sformatf("a%0d_ovf", i), a_ovf, tv[i].eo);
      a_en = tv[i].en;
      a_in = tv[i].din;
      a_if.out_ready = tv[i].rdy;
      a_clr = tv[i].clr;
    end

    b_if.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("b%0d_valid", k), b_if.out_valid, k % 2);
      chk($sformatf("b%0d_count", k), b_count, k % 2);
      if (k % 2 == 1) chk($sformatf("b%0d_data", k), b_if.out_data, k - 1);
      b_en = 1'b1;
      b_in = 8'(k);
    end
    @(negedge clk);
    b_en = 1'b0;
    chk("b_ovf", b_ovf, 0);

    a_if.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_en = (i < 8);
      a_in = 8'(30 + i);
      a_if.out_ready = (i == 8);
    end
    @(negedge clk);
    chk("pre_rst_count", a_count, 3);
    chk("pre_rst_ovf", a_ovf, 1);
    chk("pre_rst_data", a_if.out_data, 34);
    a_en = 1'b0;
    a_if.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_count", a_count, 0);
    chk("async_valid", a_if.out_valid, 0);
    chk("async_ovf", a_ovf, 0);
    chk("async_data", a_if.out_data, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rewarm%0d_valid", i), a_if.out_valid, (i == 4) ? 1 : 0);
      if (i == 4) begin
        chk("rewarm_data", a_if.out_data, 43);
        chk("rewarm_count", a_count, 1);
      end
      a_en = 1'b1;
      a_in = 8'(40 + i);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
